// File: rtl/shared_addsub_pkg.sv
// Shared types for the time-multiplexed add/sub scheduler.
package shared_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EX1  = 2'd1,
        ST_EX2  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/shared_addsub_sched_if.sv
// Request/response bundle between arithmetic clients and the shared add/sub scheduler.
interface shared_addsub_sched_if #(
    parameter int WIDTH = 16,
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ-1:0]       req_sub;
    logic [N_REQ-1:0]       req_pair;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ*WIDTH-1:0] req_c;
    logic [N_REQ*WIDTH-1:0] req_d;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [ID_W-1:0]        rsp_id;
    logic [2*WIDTH-1:0]     rsp_data;
    logic                   busy;

    modport master (
        output req_valid, req_sub, req_pair, req_a, req_b, req_c, req_d, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_sub, req_pair, req_a, req_b, req_c, req_d, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, busy
    );
endinterface

// File: rtl/shared_addsub_rr_pick.sv
// Combinational round-robin picker: first valid index strictly after i_ptr, wrapping.
module shared_addsub_rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] i_valid,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [ID_W-1:0]  o_grant_idx,
    output logic             o_any
);
    logic [ID_W-1:0] w_idx;

    // Scan from farthest to nearest so the closest valid index after i_ptr wins.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = |i_valid;
        w_idx       = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_idx = ID_W'((int'(i_ptr) + k) % N_REQ);
            if (i_valid[w_idx]) o_grant_idx = w_idx;
        end
        if (o_any) o_grant[o_grant_idx] = 1'b1;
    end
endmodule

// File: rtl/shared_addsub_sched.sv
// One WIDTH-bit add/sub unit shared round-robin between N_REQ requesters; pair ops take two passes.
module shared_addsub_sched #(
    parameter int WIDTH = 16,
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input logic               clk,
    input logic               rst,
    shared_addsub_sched_if.slave bus
);
    import shared_addsub_pkg::*;

    state_t             r_state, w_next;
    logic [ID_W-1:0]    r_ptr, r_id;
    logic [WIDTH-1:0]   r_a, r_b, r_c, r_d;
    logic               r_sub, r_pair;
    logic [2*WIDTH-1:0] r_res;

    logic [N_REQ-1:0]   w_grant;
    logic [ID_W-1:0]    w_grant_idx;
    logic               w_any, w_take;
    logic [WIDTH-1:0]   w_opa, w_opb, w_alu;

    shared_addsub_rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
        .i_valid     (bus.req_valid),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any       (w_any)
    );

    assign w_take = (r_state == ST_IDLE) && w_any;

    // The only adder: operands steered by phase, subtract as a + ~b + 1.
    assign w_opa = (r_state == ST_EX2) ? r_c : r_a;
    assign w_opb = (r_state == ST_EX2) ? r_d : r_b;
    assign w_alu = w_opa + (w_opb ^ {WIDTH{r_sub == OP_SUB}}) + {{(WIDTH-1){1'b0}}, r_sub == OP_SUB};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_any) w_next = ST_EX1;
            ST_EX1:  w_next = r_pair ? ST_EX2 : ST_DONE;
            ST_EX2:  w_next = ST_DONE;
            ST_DONE: if (bus.rsp_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = w_take ? w_grant : '0;
        bus.rsp_valid = (r_state == ST_DONE);
        bus.busy      = (r_state != ST_IDLE);
    end

    assign bus.rsp_id   = r_id;
    assign bus.rsp_data = r_res;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr  <= ID_W'(N_REQ - 1);
            r_id   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_c    <= '0;
            r_d    <= '0;
            r_sub  <= 1'b0;
            r_pair <= 1'b0;
            r_res  <= '0;
        end else begin
            if (w_take) begin
                r_ptr  <= w_grant_idx;
                r_id   <= w_grant_idx;
                r_a    <= bus.req_a[w_grant_idx*WIDTH +: WIDTH];
                r_b    <= bus.req_b[w_grant_idx*WIDTH +: WIDTH];
                r_c    <= bus.req_c[w_grant_idx*WIDTH +: WIDTH];
                r_d    <= bus.req_d[w_grant_idx*WIDTH +: WIDTH];
                r_sub  <= bus.req_sub[w_grant_idx];
                r_pair <= bus.req_pair[w_grant_idx];
            end
            if (r_state == ST_EX1) begin
                if (r_pair) r_res[2*WIDTH-1:WIDTH] <= w_alu;
                else        r_res <= {{WIDTH{1'b0}}, w_alu};
            end
            if (r_state == ST_EX2) r_res[WIDTH-1:0] <= w_alu;
        end
    end
endmodule

// File: tb/tb_shared_addsub_sched.sv
// Bench for shared_addsub_sched: vector table, scoreboard-checked responses, corner sequences.
module tb_shared_addsub_sched;
    localparam int W = 16;
    localparam int N = 4;

    typedef struct {
        int          id;
        bit          sub;
        bit          pair;
        logic [15:0] a, b, c, d;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    shared_addsub_sched_if #(.WIDTH(W), .N_REQ(N), .ID_W(2)) bus ();

    shared_addsub_sched #(.WIDTH(W), .N_REQ(N), .ID_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input bit sub, input bit pair,
                                          input logic [15:0] a, b, c, d);
        logic [15:0] hi, lo;
        hi = sub ? a - b : a + b;
        lo = sub ? c - d : c + d;
        return pair ? {hi, lo} : {16'h0000, hi};
    endfunction

    task automatic drive_req(input int id, input bit sub, input bit pair,
                             input logic [15:0] a, b, c, d);
        bus.req_sub[id]         = sub;
        bus.req_pair[id]        = pair;
        bus.req_a[id*W +: W]    = a;
        bus.req_b[id*W +: W]    = b;
        bus.req_c[id*W +: W]    = c;
        bus.req_d[id*W +: W]    = d;
        bus.req_valid[id]       = 1'b1;
    endtask

    task automatic push_exp(input int id, input logic [31:0] data);
        exp_t e;
        e.id = id;
        e.data = data;
        sb.push_back(e);
    endtask

    // Waits (bounded) for a negedge with any req_ready bit set.
    task automatic wait_grant(input string name, output logic [3:0] g);
        int n;
        g = '0;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.req_ready != 0) begin
                g = bus.req_ready;
                break;
            end
        end
        if (n >= 50) chk({name, " grant timeout"}, 0, 1);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({name, " drain"}, sb.size(), 0);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        logic [3:0] g;
        int lat;
        @(posedge clk); #1;
        drive_req(v.id, v.sub, v.pair, v.a, v.b, v.c, v.d);
        wait_grant(name, g);
        chk({name, " ready"}, g, 4'b1 << v.id);
        push_exp(v.id, v.exp);
        lat = 0;
        fork
            begin
                @(posedge clk); #1;
                bus.req_valid[v.id] = 1'b0;
            end
        join_none
        while (lat < 50) begin
            @(negedge clk);
            lat++;
            if (bus.rsp_valid) break;
        end
        chk({name, " latency"}, lat, v.lat);
    endtask

    // Scoreboard: every accepted response is compared against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected rsp", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_id", bus.rsp_id, e.id);
                chk("rsp_data", bus.rsp_data, e.data);
            end
        end
    end

    vec_t tbl[6];
    int   order[5] = '{0, 1, 2, 3, 0};

    initial begin
        logic [3:0] g;
        vec_t v;

        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_sub   = '0;
        bus.req_pair  = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_c     = '0;
        bus.req_d     = '0;
        bus.rsp_ready = 1'b1;

        tbl[0] = '{0, 1'b0, 1'b0, 16'h0003, 16'h0004, 16'h0000, 16'h0000, 32'h0000_0007, 2};
        tbl[1] = '{2, 1'b1, 1'b1, 16'h0000, 16'h0001, 16'h1234, 16'h0234, 32'hFFFF_1000, 3};
        tbl[2] = '{1, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 32'h0000_0000, 2};
        tbl[3] = '{3, 1'b0, 1'b1, 16'h8000, 16'h8000, 16'h7FFF, 16'h0001, 32'h0000_8000, 3};
        tbl[4] = '{1, 1'b1, 1'b0, 16'h0005, 16'h0007, 16'hDEAD, 16'hBEEF, 32'h0000_FFFE, 2};
        tbl[5] = '{0, 1'b0, 1'b1, 16'h1111, 16'h2222, 16'hAAAA, 16'h5555, 32'h3333_FFFF, 3};

        #12;
        chk("reset req_ready", bus.req_ready, 0);
        chk("reset rsp_valid", bus.rsp_valid, 0);
        chk("reset busy", bus.busy, 0);
        chk("reset rsp_id", bus.rsp_id, 0);
        chk("reset rsp_data", bus.rsp_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("vec%0d", i));
        for (int i = 0; i < 6; i++) begin
            v.id   = $urandom_range(0, N-1);
            v.sub  = 1'($urandom_range(0, 1));
            v.pair = 1'($urandom_range(0, 1));
            v.a    = 16'($urandom);
            v.b    = 16'($urandom);
            v.c    = 16'($urandom);
            v.d    = 16'($urandom);
            v.exp  = model(v.sub, v.pair, v.a, v.b, v.c, v.d);
            v.lat  = v.pair ? 3 : 2;
            run_vec(v, $sformatf("rnd%0d", i));
        end
        drain("vectors");

        // All requesters held valid after a fresh reset: strict rotation from 0.
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < N; k++)
            drive_req(k, 1'b0, 1'b0, 16'(16'h1000 * (k + 1)), 16'(k + 1), 16'h0, 16'h0);
        for (int i = 0; i < 5; i++) begin
            wait_grant("rr", g);
            chk($sformatf("rr grant%0d", i), g, 4'b1 << order[i]);
            push_exp(order[i], model(1'b0, 1'b0, 16'(16'h1000 * (order[i] + 1)),
                                     16'(order[i] + 1), 16'h0, 16'h0));
            @(posedge clk); #1;
            if (i == 4) bus.req_valid = '0;
            @(negedge clk);
            chk($sformatf("rr pulse%0d", i), bus.req_ready, 0);
        end
        drain("rr");

        // Response back-pressure: DONE holds while another requester waits.
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        drive_req(3, 1'b1, 1'b0, 16'h0010, 16'h0020, 16'h0, 16'h0);
        wait_grant("stall", g);
        chk("stall grant", g, 4'b1000);
        push_exp(3, 32'h0000_FFF0);
        @(posedge clk); #1;
        bus.req_valid[3] = 1'b0;
        drive_req(1, 1'b0, 1'b0, 16'h0001, 16'h0001, 16'h0, 16'h0);
        for (int n = 0; n < 20 && !bus.rsp_valid; n++) @(negedge clk);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("stall rsp_valid", bus.rsp_valid, 1);
            chk("stall rsp_id", bus.rsp_id, 3);
            chk("stall rsp_data", bus.rsp_data, 32'h0000_FFF0);
            chk("stall req_ready", bus.req_ready, 0);
            chk("stall busy", bus.busy, 1);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        wait_grant("stall next", g);
        chk("stall next grant", g, 4'b0010);
        push_exp(1, 32'h0000_0002);
        @(posedge clk); #1;
        bus.req_valid[1] = 1'b0;
        drain("stall");

        // Reset in EX2 of a pair: response dropped, arbitration restarts at 0.
        @(posedge clk); #1;
        drive_req(2, 1'b0, 1'b1, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
        wait_grant("rst", g);
        chk("rst grant", g, 4'b0100);
        @(posedge clk); #1;
        bus.req_valid[2] = 1'b0;
        @(posedge clk); #1;
        chk("rst pre busy", bus.busy, 1);
        chk("rst pre rsp_valid", bus.rsp_valid, 0);
        rst = 1'b1;
        #1;
        chk("rst rsp_valid", bus.rsp_valid, 0);
        chk("rst busy", bus.busy, 0);
        chk("rst req_ready", bus.req_ready, 0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        drive_req(0, 1'b0, 1'b0, 16'h0100, 16'h0020, 16'h0, 16'h0);
        drive_req(3, 1'b0, 1'b0, 16'h0001, 16'h0001, 16'h0, 16'h0);
        wait_grant("post rst", g);
        chk("post rst grant", g, 4'b0001);
        push_exp(0, 32'h0000_0120);
        @(posedge clk); #1;
        bus.req_valid = '0;
        drain("post rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
